// File: rtl/des_round_key_scheduler_if.sv
// ---------------------------------------------------------------------------
// des_round_key_scheduler_if
//   Bundles the load request and subkey handshake of the DES round-key
//   scheduler. Bit vectors use ascending ranges so that index k is FIPS 46-3
//   bit k (bit 1 is the leftmost/most significant bit).
//
//   master : the side that loads C0/D0 and consumes subkeys (round datapath)
//   slave  : the scheduler itself
//
//   load          start request (sampled only while idle)
//   decrypt       0 = K1..K16, 1 = K16..K1 (sampled with load)
//   c_in, d_in    C0 / D0 halves from PC-1
//   subkey_out    current subkey Kn
//   subkey_valid  subkey_out holds a valid subkey
//   subkey_ready  consumer accepts the subkey
//   round_num     n-1 of the presented subkey
//   busy          schedule in progress
//   done          one-cycle pulse after the final transfer
//   weak_key      weak-key flag (0 unless detection is built)
// ---------------------------------------------------------------------------
interface des_round_key_scheduler_if;
  logic        load;
  logic        decrypt;
  logic [1:28] c_in;
  logic [1:28] d_in;
  logic [1:48] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;
  logic        weak_key;

  modport master (
    output load, decrypt, c_in, d_in, subkey_ready,
    input  subkey_out, subkey_valid, round_num, busy, done, weak_key
  );

  modport slave (
    input  load, decrypt, c_in, d_in, subkey_ready,
    output subkey_out, subkey_valid, round_num, busy, done, weak_key
  );
endinterface

// File: rtl/des_round_key_scheduler.sv
// ---------------------------------------------------------------------------
// des_round_key_scheduler
//   Generates the DES round subkeys from the PC-1 halves C0/D0, one subkey per
//   valid/ready transfer, in encrypt order (K1..K16) or decrypt order
//   (K16..K1). Each subkey is the per-round circular shift of C/D followed
//   by PC-2. The first subkey is valid one cycle after the load edge.
//
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous active-high reset (aborts any schedule)
//     key_if  des_round_key_scheduler_if.slave (load + subkey handshake)
//
//   Parameter:
//     ROUNDS  subkeys issued per load, 1..16 (below 16 is for reduced-round
//             testing only)
//
//   Optional build macro:
//     DES_KEY_WEAK_KEY_DETECT_EN  when defined, key_if.weak_key is registered
//     on each accepted load and flags the four DES weak keys (C0 and D0 each
//     all-0 or all-1). When undefined, weak_key is tied to 0.
// ---------------------------------------------------------------------------
module des_round_key_scheduler #(
  parameter int ROUNDS = 16
) (
  input logic                         clk,
  input logic                         rst,
  des_round_key_scheduler_if.slave    key_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

  // Shift amount for issue step 1..16. Encrypt rotates left by the FIPS
  // per-round schedule. Decrypt rotates right, walking that schedule
  // backwards: step 1 uses C0/D0 as-is because C16/D16 equal C0/D0.
  function automatic logic [1:0] shift_amt(input logic [4:0] step, input logic right);
    if (right) begin
      if (step == 5'd1)
        return 2'd0;
      else if (step == 5'd2 || step == 5'd9 || step == 5'd16)
        return 2'd1;
      else
        return 2'd2;
    end else begin
      if (step == 5'd1 || step == 5'd2 || step == 5'd9 || step == 5'd16)
        return 2'd1;
      else
        return 2'd2;
    end
  endfunction

  // Circular rotate of a 28-bit half in FIPS indexing: left moves bit k+1
  // into bit k (bit 1 wraps to 28), right moves bit k-1 into bit k.
  function automatic logic [1:28] rot28(input logic [1:28] v, input logic [1:0] amt,
                                        input logic right);
    logic [1:28] r;
    r = v;
    if (right) begin
      if (amt == 2'd1)
        r = {v[28], v[1:27]};
      else if (amt == 2'd2)
        r = {v[27:28], v[1:26]};
    end else begin
      if (amt == 2'd1)
        r = {v[2:28], v[1]};
      else if (amt == 2'd2)
        r = {v[3:28], v[1:2]};
    end
    return r;
  endfunction

  // PC-2: picks 48 of the 56 bits of CD = {C, D}; bit j of the result is
  // CD[PC2[j]] with the FIPS 46-3 table.
  function automatic logic [1:48] pc2(input logic [1:56] cd);
    return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
            cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
            cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
            cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
            cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
            cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
            cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
            cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
  endfunction

  logic [1:0]  state_q,  state_d;
  logic [1:28] c_q,      c_d;
  logic [1:28] d_q,      d_d;
  logic [1:48] subkey_q, subkey_d;
  logic        valid_q,  valid_d;
  logic [3:0]  round_q,  round_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic        mode_q,   mode_d;     // 1 = decrypt order
  logic [4:0]  issued_q, issued_d;   // subkeys presented so far, 1..ROUNDS

  logic [4:0]  next_step;
  logic [1:28] c_rot, d_rot, c_first, d_first;
  logic        xfer;

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    subkey_d  = subkey_q;
    valid_d   = valid_q;
    round_d   = round_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mode_d    = mode_q;
    issued_d  = issued_q;

    next_step = issued_q + 5'd1;
    xfer      = valid_q & key_if.subkey_ready;
    c_rot     = rot28(c_q, shift_amt(next_step, mode_q), mode_q);
    d_rot     = rot28(d_q, shift_amt(next_step, mode_q), mode_q);
    c_first   = rot28(key_if.c_in, shift_amt(5'd1, key_if.decrypt), key_if.decrypt);
    d_first   = rot28(key_if.d_in, shift_amt(5'd1, key_if.decrypt), key_if.decrypt);

    case (state_q)
      ST_IDLE: begin
        if (key_if.load) begin
          mode_d   = key_if.decrypt;
          c_d      = c_first;
          d_d      = d_first;
          subkey_d = pc2({c_first, d_first});
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          issued_d = 5'd1;
          round_d  = key_if.decrypt ? 4'd15 : 4'd0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (issued_q < ROUNDS_W) begin
            c_d      = c_rot;
            d_d      = d_rot;
            subkey_d = pc2({c_rot, d_rot});
            round_d  = mode_q ? (round_q - 4'd1) : (round_q + 4'd1);
            issued_d = next_step;
          end else begin
            valid_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      d_q      <= '0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      round_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      issued_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      subkey_q <= subkey_d;
      valid_q  <= valid_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      issued_q <= issued_d;
    end
  end

  assign key_if.subkey_out   = subkey_q;
  assign key_if.subkey_valid = valid_q;
  assign key_if.round_num    = round_q;
  assign key_if.busy         = busy_q;
  assign key_if.done         = done_q;

`ifdef DES_KEY_WEAK_KEY_DETECT_EN
  logic weak_q, weak_d;
  logic c_uniform, d_uniform;

  always_comb begin
    c_uniform = (key_if.c_in == '0) || (key_if.c_in == '1);
    d_uniform = (key_if.d_in == '0) || (key_if.d_in == '1);
    weak_d    = weak_q;
    if (state_q == ST_IDLE && key_if.load)
      weak_d = c_uniform & d_uniform;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      weak_q <= 1'b0;
    else
      weak_q <= weak_d;
  end

  assign key_if.weak_key = weak_q;
`else
  assign key_if.weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_round_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_des_round_key_scheduler
//   Directed bench for des_round_key_scheduler using the FIPS example key
//   133457799BBCDFF1 (C0/D0 below) and its published subkeys K1..K16.
//   Outputs are sampled 1 time unit after the rising edge; inputs are driven
//   at the same point so they are stable for the next edge.
// ---------------------------------------------------------------------------
module tb_des_round_key_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_round_key_scheduler_if key_if ();

  des_round_key_scheduler #(.ROUNDS(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .key_if (key_if)
  );

  localparam logic [1:28] C0 = 28'b1111000011001100101010101111;
  localparam logic [1:28] D0 = 28'b0101010101100110011110001111;

  logic [1:48] kexp [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int vectors    = 0;
  int miscompares = 0;

  // Presents a load for one edge; returns 1 unit after that edge.
  task automatic do_load(input logic dec, input logic [1:28] c, input logic [1:28] d);
    key_if.load    = 1'b1;
    key_if.decrypt = dec;
    key_if.c_in    = c;
    key_if.d_in    = d;
    @(posedge clk); #1;
    key_if.load    = 1'b0;
    key_if.decrypt = ~dec;
    key_if.c_in    = ~c;
    key_if.d_in    = ~d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_if.load = 1'b0;
    key_if.decrypt = 1'b0;
    key_if.c_in = '0;
    key_if.d_in = '0;
    key_if.subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (key_if.subkey_valid !== 1'b0 || key_if.busy !== 1'b0 || key_if.done !== 1'b0 ||
        key_if.weak_key !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got valid=%b busy=%b done=%b weak=%b, expected all 0",
               key_if.subkey_valid, key_if.busy, key_if.done, key_if.weak_key);
    end
    vectors++;
    if (key_if.subkey_out !== 48'h0 || key_if.round_num !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: got subkey=%h round=%0d, expected 0/0",
               key_if.subkey_out, key_if.round_num);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: outputs checked");
  endtask

  // Full schedule with ready held high; dec selects the order.
  task automatic test_order(input logic dec);
    int k;
    key_if.subkey_ready = 1'b1;
    do_load(dec, C0, D0);
    for (int i = 0; i < 16; i++) begin
      k = dec ? 15 - i : i;
      vectors++;
      if (key_if.subkey_valid !== 1'b1 || key_if.subkey_out !== kexp[k] ||
          key_if.round_num !== k[3:0] || key_if.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_step%0d: got valid=%b subkey=%h round=%0d busy=%b, expected 1/%h/%0d/1",
                 dec ? "dec" : "enc", i, key_if.subkey_valid, key_if.subkey_out,
                 key_if.round_num, key_if.busy, kexp[k], k);
      end
      $display("%s step %0d: subkey=%h round=%0d", dec ? "dec" : "enc", i,
               key_if.subkey_out, key_if.round_num);
      @(posedge clk); #1;
    end
    vectors++;
    if (key_if.subkey_valid !== 1'b0 || key_if.done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: got valid=%b done=%b, expected 0/1", dec ? "dec" : "enc",
               key_if.subkey_valid, key_if.done);
    end
    @(posedge clk); #1;
    vectors++;
    if (key_if.done !== 1'b0 || key_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got done=%b busy=%b, expected 0/0", dec ? "dec" : "enc",
               key_if.done, key_if.busy);
    end
  endtask

  task automatic test_encrypt();
    test_order(1'b0);
  endtask

  // Starts immediately after the encrypt run, so it also covers reload timing.
  task automatic test_back_to_back_decrypt();
    test_order(1'b1);
  endtask

  task automatic test_stall();
    int idx   = 0;
    int stall = 0;
    int xfers = 0;
    key_if.subkey_ready = 1'b1;
    do_load(1'b0, C0, D0);
    for (int cyc = 0; cyc < 40 && idx < 16; cyc++) begin
      vectors++;
      if (key_if.subkey_valid !== 1'b1 || key_if.subkey_out !== kexp[idx] ||
          key_if.round_num !== idx[3:0]) begin
        miscompares++;
        $display("FAIL stall_cyc%0d: got valid=%b subkey=%h round=%0d, expected 1/%h/%0d",
                 cyc, key_if.subkey_valid, key_if.subkey_out, key_if.round_num, kexp[idx], idx);
      end
      if (idx == 2 && stall < 5) begin
        key_if.subkey_ready = 1'b0;
        stall++;
      end else begin
        key_if.subkey_ready = 1'b1;
        if (key_if.subkey_valid === 1'b1) xfers++;
        idx++;
      end
      @(posedge clk); #1;
    end
    key_if.subkey_ready = 1'b1;
    vectors++;
    if (xfers != 16 || key_if.done !== 1'b1 || key_if.subkey_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_count: got transfers=%0d done=%b valid=%b, expected 16/1/0",
               xfers, key_if.done, key_if.subkey_valid);
    end
    $display("stall: %0d transfers, %0d stall cycles", xfers, stall);
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int n;
    key_if.subkey_ready = 1'b1;
    do_load(1'b0, C0, D0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (key_if.subkey_out !== kexp[i] || key_if.round_num !== i[3:0]) begin
        miscompares++;
        $display("FAIL abort_step%0d: got subkey=%h round=%0d, expected %h/%0d",
                 i, key_if.subkey_out, key_if.round_num, kexp[i], i);
      end
      // Stray load during round 7 with a different key and order.
      if (i == 6) begin
        key_if.load = 1'b1;
        key_if.decrypt = 1'b1;
        key_if.c_in = '0;
        key_if.d_in = '0;
      end else begin
        key_if.load = 1'b0;
      end
      @(posedge clk); #1;
    end
    key_if.load = 1'b0;
    vectors++;
    if (key_if.subkey_out !== kexp[8] || key_if.round_num !== 4'd8) begin
      miscompares++;
      $display("FAIL abort_round9: got subkey=%h round=%0d, expected %h/8",
               key_if.subkey_out, key_if.round_num, kexp[8]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (key_if.subkey_valid !== 1'b0 || key_if.subkey_out !== 48'h0 ||
        key_if.round_num !== 4'd0 || key_if.busy !== 1'b0 || key_if.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: got valid=%b subkey=%h round=%0d busy=%b done=%b, expected all 0",
               key_if.subkey_valid, key_if.subkey_out, key_if.round_num, key_if.busy, key_if.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (key_if.subkey_valid !== 1'b0 || key_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got valid=%b busy=%b, expected 0/0",
               key_if.subkey_valid, key_if.busy);
    end
    do_load(1'b0, C0, D0);
    vectors++;
    if (key_if.subkey_valid !== 1'b1 || key_if.subkey_out !== kexp[0] ||
        key_if.round_num !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_restart: got valid=%b subkey=%h round=%0d, expected 1/%h/0",
               key_if.subkey_valid, key_if.subkey_out, key_if.round_num, kexp[0]);
    end
    n = 0;
    while (n < 40 && key_if.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (key_if.done !== 1'b1 || n != 16) begin
      miscompares++;
      $display("FAIL abort_rerun_done: got done=%b after %0d cycles, expected 1 after 16",
               key_if.done, n);
    end
    $display("abort: reset mid-schedule, restart finished after %0d cycles", n);
    @(posedge clk); #1;
  endtask

  task automatic test_weak_key();
    int n;
    logic exp_weak;
`ifdef DES_KEY_WEAK_KEY_DETECT_EN
    exp_weak = 1'b1;
`else
    exp_weak = 1'b0;
`endif
    key_if.subkey_ready = 1'b1;
    do_load(1'b0, 28'h0000000, 28'hFFFFFFF);
    vectors++;
    if (key_if.weak_key !== exp_weak || key_if.subkey_out !== 48'h000000FFFFFF) begin
      miscompares++;
      $display("FAIL weak_load: got weak=%b subkey=%h, expected %b/000000ffffff",
               key_if.weak_key, key_if.subkey_out, exp_weak);
    end
    n = 0;
    while (n < 40 && key_if.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    vectors++;
    if (key_if.weak_key !== exp_weak || key_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL weak_hold: got weak=%b busy=%b, expected %b/0",
               key_if.weak_key, key_if.busy, exp_weak);
    end
    do_load(1'b0, C0, D0);
    vectors++;
    if (key_if.weak_key !== 1'b0 || key_if.subkey_out !== kexp[0]) begin
      miscompares++;
      $display("FAIL weak_clear: got weak=%b subkey=%h, expected 0/%h",
               key_if.weak_key, key_if.subkey_out, kexp[0]);
    end
    n = 0;
    while (n < 40 && key_if.done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (key_if.done !== 1'b1) begin
      miscompares++;
      $display("FAIL weak_done: got done=%b, expected 1", key_if.done);
    end
    $display("weak_key: expected flag %b checked", exp_weak);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back_decrypt();
    test_stall();
    test_abort();
    test_weak_key();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_round_key_scheduler.md
Name: des_round_key_scheduler

Overview:
- Downstream of the PC-1 key stage. Takes the 28-bit C0/D0 halves it produces and generates the 16 DES round subkeys, one per handshake.
- Each subkey is produced by per-round circular shifts followed by PC-2.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Feeds the round/f-function datapath through a valid/ready interface.

Parameters:
- ROUNDS, 16, number of subkeys issued per load. Values 1..16 are legal; values below 16 stop early and are for reduced-round test use only.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LOAD  input  1  start request; sampled only in IDLE. Assert only while the PC-1 stage is selected (outputs not Z).
- DECRYPT  input  1  sampled with LOAD. 0 = K1..K16, 1 = K16..K1.
- C_IN  input  28  C0 half from PC-1. Index k = FIPS bit k of C.
- D_IN  input  28  D0 half from PC-1. Index k = FIPS bit k of D.
- SUBKEY_OUT  output  48  current subkey. Index j = FIPS bit j of Kn.
- SUBKEY_VALID  output  1  SUBKEY_OUT holds a valid subkey.
- SUBKEY_READY  input  1  consumer accepts the subkey.
- ROUND_NUM  output  4  FIPS round index n of the presented subkey, encoded as n-1 (0..15).
- BUSY  output  1  schedule in progress.
- DONE  output  1  one-cycle pulse after the final transfer.
- WEAK_KEY  output  1  weak-key flag (see Optional Feature).

Behaviour:
- Reset: async, active-high. Return to IDLE. C/D registers = 0, SUBKEY_OUT = 0, SUBKEY_VALID = 0, ROUND_NUM = 0, BUSY = 0, DONE = 0, WEAK_KEY = 0. Assertion mid-schedule aborts immediately; no further subkeys are issued.
- States: IDLE, ISSUE, FIN.
- IDLE: on LOAD = 1 at a rising edge:
  - latch DECRYPT into a mode register;
  - C/D <= rot(C_IN, D_IN, s1);
  - SUBKEY_OUT <= PC2 of that result;
  - SUBKEY_VALID <= 1; BUSY <= 1; go to ISSUE.
  - Latency from LOAD edge to first valid subkey: 1 cycle.
- Encrypt shift schedule (left rotate, per round 1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt shift schedule (right rotate, per issue step): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Step 1 uses C0/D0 unrotated, since C16 = C0.
- Rotation convention, FIPS indexing:
  - left by 1: new[k] = old[k+1], new[28] = old[1];
  - right by 1: new[k] = old[k-1], new[1] = old[28].
- PC-2: CD[1..28] = C, CD[29..56] = D. SUBKEY_OUT[j] = CD[PC2[j]] using the standard FIPS 46-3 table.
- ISSUE:
  - A transfer occurs on an edge where SUBKEY_VALID & SUBKEY_READY.
  - On a transfer with issued count < ROUNDS: compute the next rotation and SUBKEY_OUT, advance ROUND_NUM (+1 encrypt, -1 decrypt). SUBKEY_VALID stays 1, so back-to-back throughput is 1 subkey/cycle.
  - If READY = 0: SUBKEY_OUT, ROUND_NUM and C/D hold stable.
  - On the final transfer: SUBKEY_VALID <= 0; go to FIN.
- FIN: DONE = 1 for exactly one cycle; BUSY <= 0; go to IDLE. A new LOAD is accepted from the following cycle.
- ROUND_NUM at first issue: 0 for encrypt, 15 for decrypt.
- LOAD while BUSY: ignored, no effect. C_IN/D_IN/DECRYPT are don't-care outside the load edge.
- READY may be asserted before VALID; no combinational path from READY to VALID.

Optional Feature:
- Macro: DES_KEY_WEAK_KEY_DETECT_EN.
- When defined:
  - WEAK_KEY is registered on the load edge.
  - It is set when C_IN is all-0 or all-1 AND D_IN is all-0 or all-1 (the 4 DES weak keys).
  - It holds until the next accepted load or reset.
  - Scheduling proceeds normally; the flag is informational only.
- When undefined: WEAK_KEY tied to 0 and no detection logic is built.

Test Plan:
- Key 133457799BBCDFF1 gives C0 = 1111000011001100101010101111 and D0 = 0101010101100110011110001111 (FIPS order, bit 1 first). LOAD with DECRYPT = 0 and READY held 1 -> 16 consecutive valid cycles, starting one cycle after LOAD:
  - K1 = 000110110000001011101111111111000111000001110010 (1B02EFFC7072);
  - K2 = 79AED9DBC9E5;
  - K16 = CB3D8B0E17F5;
  - then DONE for 1 cycle and BUSY low.
- Same key with DECRYPT = 1 -> first subkey CB3D8B0E17F5 with ROUND_NUM = 15; last subkey 1B02EFFC7072 with ROUND_NUM = 0.
- Encrypt with READY low for 5 cycles at round 3 -> SUBKEY_OUT and ROUND_NUM = 2 held stable; sequence resumes unchanged; exactly 16 transfers.
- LOAD pulsed during round 7, then RESET asserted mid-cycle at round 9 -> the mid-schedule LOAD has no effect; on RESET all outputs go to 0 immediately; a fresh LOAD then restarts at K1.
- C_IN = all-0, D_IN = all-1 with the macro defined -> WEAK_KEY = 1 after load; a subsequent normal key clears it. With the macro undefined -> WEAK_KEY stays 0.
